// File: rtl/reservation_station_pkg.sv
// Shared widths, bus payload types and helpers for the reservation station.
package reservation_station_pkg;

   localparam int unsigned RS_LEN  = 8;
   localparam int unsigned ROB_LEN = 32;
   localparam int unsigned ROB_W   = $clog2(ROB_LEN);
   localparam int unsigned XLEN    = 32;
   localparam int unsigned INST_W  = 32;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned FUNC_W  = 4;

   typedef logic [ROB_W-1:0] rob_tag_t;

   typedef struct packed {
      logic              valid;
      logic [INST_W-1:0] inst;
      logic [XLEN-1:0]   rs1_value;
      logic [XLEN-1:0]   rs2_value;
      logic [REG_W-1:0]  dest_reg_idx;
      logic [FUNC_W-1:0] alu_func;
   } id_packet_t;

   typedef struct packed {
      rob_tag_t rs1_tag;
      rob_tag_t rs2_tag;
      logic     rs1_ready;
      logic     rs2_ready;
   } mt2rs_packet_t;

   typedef struct packed {
      rob_tag_t        rob_entry;
      logic [XLEN-1:0] rs1_value;
      logic [XLEN-1:0] rs2_value;
      rob_tag_t        rob_head_idx;
   } rob2rs_packet_t;

   typedef struct packed {
      rob_tag_t        reg_tag;
      logic [XLEN-1:0] reg_value;
   } cdb_packet_t;

   typedef struct packed {
      rob_tag_t rs1_tag;
      rob_tag_t rs2_tag;
   } rs2rob_packet_t;

   typedef struct packed {
      logic [REG_W-1:0] dest_reg_idx;
      rob_tag_t         rob_entry;
      logic             valid;
   } rs2mt_packet_t;

   typedef struct packed {
      logic              valid;
      logic [INST_W-1:0] inst;
      logic [XLEN-1:0]   rs1_value;
      logic [XLEN-1:0]   rs2_value;
      logic [REG_W-1:0]  dest_reg_idx;
      logic [FUNC_W-1:0] alu_func;
      rob_tag_t          rob_entry;
   } is_packet_t;

   // One source operand held in a slot: value is meaningful only when ready.
   typedef struct packed {
      logic            ready;
      rob_tag_t        tag;
      logic [XLEN-1:0] value;
   } operand_t;

   // Distance of a ROB entry from the head, modulo ROB_LEN (smaller = older).
   function automatic rob_tag_t rob_age(rob_tag_t entry, rob_tag_t head);
      return ROB_W'(entry - head);
   endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Dispatch/issue side bus of the reservation station.
interface reservation_station_if;
   import reservation_station_pkg::*;

   id_packet_t              id_packet_in;
   mt2rs_packet_t           mt2rs_packet_in;
   rob2rs_packet_t          rob2rs_packet_in;
   cdb_packet_t             cdb_packet_in;
   logic [RS_LEN-1:0]       rs_entry_clear_in;
   rs2rob_packet_t          rs2rob_packet_out;
   rs2mt_packet_t           rs2mt_packet_out;
   is_packet_t              is_packet_out;
   logic [RS_LEN-1:0]       rs_entry_clear_out;
   logic                    valid;

   modport slave (
      input  id_packet_in, mt2rs_packet_in, rob2rs_packet_in, cdb_packet_in, rs_entry_clear_in,
      output rs2rob_packet_out, rs2mt_packet_out, is_packet_out, rs_entry_clear_out, valid
   );

   modport master (
      output id_packet_in, mt2rs_packet_in, rob2rs_packet_in, cdb_packet_in, rs_entry_clear_in,
      input  rs2rob_packet_out, rs2mt_packet_out, is_packet_out, rs_entry_clear_out, valid
   );

endinterface

// File: rtl/reservation_station_entry.sv
// One reservation-station slot: holds a renamed instruction and snoops the CDB.
module reservation_station_entry
   import reservation_station_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              clear,
   input  cdb_packet_t       cdb,
   input  operand_t          rs1_init,
   input  operand_t          rs2_init,
   input  rob_tag_t          rob_entry_in,
   input  logic [INST_W-1:0] inst_in,
   input  logic [REG_W-1:0]  dest_reg_idx_in,
   input  logic [FUNC_W-1:0] alu_func_in,
   output logic              busy,
   output logic              ready,
   output rob_tag_t          rob_entry,
   output is_packet_t        is_packet
);

   logic              busy_q;
   operand_t          rs1_q;
   operand_t          rs2_q;
   rob_tag_t          rob_q;
   logic [INST_W-1:0] inst_q;
   logic [REG_W-1:0]  dest_q;
   logic [FUNC_W-1:0] func_q;

   // A waiting operand captures the broadcast value when its tag matches; tag 0 never matches.
   function automatic operand_t wake(operand_t op, cdb_packet_t c);
      operand_t r;
      r = op;
      if (!op.ready && (c.reg_tag != '0) && (c.reg_tag == op.tag)) begin
         r.ready = 1'b1;
         r.value = c.reg_value;
      end
      return r;
   endfunction

   // Slot state: a new dispatch wins over a clear so a freed slot can be refilled at once.
   always_ff @(posedge clock) begin
      if (reset) begin
         busy_q <= 1'b0;
         rs1_q  <= '0;
         rs2_q  <= '0;
         rob_q  <= '0;
         inst_q <= '0;
         dest_q <= '0;
         func_q <= '0;
      end else if (enable) begin
         busy_q <= 1'b1;
         rs1_q  <= rs1_init;
         rs2_q  <= rs2_init;
         rob_q  <= rob_entry_in;
         inst_q <= inst_in;
         dest_q <= dest_reg_idx_in;
         func_q <= alu_func_in;
      end else if (clear) begin
         busy_q <= 1'b0;
      end else if (busy_q) begin
         rs1_q <= wake(rs1_q, cdb);
         rs2_q <= wake(rs2_q, cdb);
      end
   end

   // Issue view of the slot.
   always_comb begin
      busy      = busy_q;
      ready     = busy_q & rs1_q.ready & rs2_q.ready;
      rob_entry = rob_q;
      is_packet = '{valid:        ready,
                    inst:         inst_q,
                    rs1_value:    rs1_q.value,
                    rs2_value:    rs2_q.value,
                    dest_reg_idx: dest_q,
                    alu_func:     func_q,
                    rob_entry:    rob_q};
   end

endmodule

// File: rtl/reservation_station.sv
// Unified reservation station: operand resolution at dispatch, CDB wakeup, oldest-ready issue.
module reservation_station
   import reservation_station_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   reservation_station_if.slave  bus
);

   logic [RS_LEN-1:0] busy;
   logic [RS_LEN-1:0] ready;
   logic [RS_LEN-1:0] free;
   logic [RS_LEN-1:0] disp_sel;
   logic [RS_LEN-1:0] issue_sel;
   rob_tag_t          entry_rob [RS_LEN];
   is_packet_t        entry_pkt [RS_LEN];
   operand_t          rs1_init;
   operand_t          rs2_init;
   is_packet_t        issue_pkt;
   rob_tag_t          age;
   rob_tag_t          best_age;
   logic              found;
   logic              has_free;
   logic              dispatch;

   // Operand source: regfile when unrenamed, ROB when produced, same-cycle CDB, else wait on tag.
   function automatic operand_t resolve(rob_tag_t tag, logic mt_ready, logic [XLEN-1:0] id_value,
                                        logic [XLEN-1:0] rob_value, cdb_packet_t cdb);
      operand_t op;
      op.tag   = tag;
      op.ready = 1'b1;
      op.value = id_value;
      if (tag != '0) begin
         if (mt_ready) begin
            op.value = rob_value;
         end else if (cdb.reg_tag == tag) begin
            op.value = cdb.reg_value;
         end else begin
            op.ready = 1'b0;
            op.value = '0;
         end
      end
      return op;
   endfunction

   assign rs1_init = resolve(bus.mt2rs_packet_in.rs1_tag, bus.mt2rs_packet_in.rs1_ready,
                             bus.id_packet_in.rs1_value, bus.rob2rs_packet_in.rs1_value,
                             bus.cdb_packet_in);
   assign rs2_init = resolve(bus.mt2rs_packet_in.rs2_tag, bus.mt2rs_packet_in.rs2_ready,
                             bus.id_packet_in.rs2_value, bus.rob2rs_packet_in.rs2_value,
                             bus.cdb_packet_in);

   // Lowest-index free slot; a slot being cleared this cycle counts as free.
   always_comb begin
      free     = ~busy | bus.rs_entry_clear_in;
      disp_sel = '0;
      for (int i = int'(RS_LEN) - 1; i >= 0; i--) begin
         if (free[i]) begin
            disp_sel    = '0;
            disp_sel[i] = 1'b1;
         end
      end
   end

   assign has_free = |free;
   assign dispatch = bus.id_packet_in.valid & has_free;

   for (genvar g = 0; g < RS_LEN; g++) begin : g_entry
      reservation_station_entry u_entry (
         .clock           (clock),
         .reset           (reset),
         .enable          (dispatch & disp_sel[g]),
         .clear           (bus.rs_entry_clear_in[g]),
         .cdb             (bus.cdb_packet_in),
         .rs1_init        (rs1_init),
         .rs2_init        (rs2_init),
         .rob_entry_in    (bus.rob2rs_packet_in.rob_entry),
         .inst_in         (bus.id_packet_in.inst),
         .dest_reg_idx_in (bus.id_packet_in.dest_reg_idx),
         .alu_func_in     (bus.id_packet_in.alu_func),
         .busy            (busy[g]),
         .ready           (ready[g]),
         .rob_entry       (entry_rob[g]),
         .is_packet       (entry_pkt[g])
      );
   end

   // Age selector: ready entry closest to the ROB head issues; ROB tags are unique so no ties.
   always_comb begin
      issue_sel = '0;
      found     = 1'b0;
      best_age  = '1;
      age       = '0;
      for (int i = 0; i < int'(RS_LEN); i++) begin
         age = rob_age(entry_rob[i], bus.rob2rs_packet_in.rob_head_idx);
         if (ready[i] && (!found || (age < best_age))) begin
            found        = 1'b1;
            best_age     = age;
            issue_sel    = '0;
            issue_sel[i] = 1'b1;
         end
      end
   end

   // Issue mux; all fields read zero when nothing is selected.
   always_comb begin
      issue_pkt = '0;
      for (int i = 0; i < int'(RS_LEN); i++) begin
         if (issue_sel[i]) begin
            issue_pkt = entry_pkt[i];
         end
      end
   end

   assign bus.is_packet_out      = issue_pkt;
   assign bus.rs_entry_clear_out = issue_sel;
   assign bus.valid              = has_free;
   assign bus.rs2rob_packet_out  = '{rs1_tag: bus.mt2rs_packet_in.rs1_tag,
                                     rs2_tag: bus.mt2rs_packet_in.rs2_tag};
   assign bus.rs2mt_packet_out   = '{dest_reg_idx: bus.id_packet_in.dest_reg_idx,
                                     rob_entry:    bus.rob2rs_packet_in.rob_entry,
                                     valid:        dispatch & (bus.id_packet_in.dest_reg_idx != '0)};

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench: directed scenarios plus random traffic against a slot-array model.
module tb_reservation_station;
   import reservation_station_pkg::*;

   logic clock = 1'b0;
   logic reset;

   reservation_station_if bus ();

   reservation_station dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit          busy;
      int          rob;
      bit          rdy1;
      int          tag1;
      logic [31:0] val1;
      bit          rdy2;
      int          tag2;
      logic [31:0] val2;
      logic [31:0] inst;
      int          dest;
      int          func;
   } slot_t;

   slot_t m [RS_LEN];
   int    checks = 0;
   int    errors = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Oldest ready slot by ROB distance from head, or -1.
   function automatic int pick_issue(int head);
      int best     = -1;
      int best_age = ROB_LEN;
      for (int i = 0; i < RS_LEN; i++) begin
         if (m[i].busy && m[i].rdy1 && m[i].rdy2) begin
            int a = (m[i].rob - head + ROB_LEN) % ROB_LEN;
            if (a < best_age) begin
               best_age = a;
               best     = i;
            end
         end
      end
      return best;
   endfunction

   function automatic int free_count();
      int n = 0;
      for (int i = 0; i < RS_LEN; i++)
         if (!m[i].busy || bus.rs_entry_clear_in[i]) n++;
      return n;
   endfunction

   task automatic check_outputs();
      int             sel     = pick_issue(int'(bus.rob2rs_packet_in.rob_head_idx));
      bit             any     = free_count() > 0;
      is_packet_t     exp_pkt = '0;
      logic [RS_LEN-1:0] exp_clr = '0;
      rs2mt_packet_t  exp_mt;
      rs2rob_packet_t exp_rob;
      if (sel >= 0) begin
         exp_pkt.valid        = 1'b1;
         exp_pkt.inst         = m[sel].inst;
         exp_pkt.rs1_value    = m[sel].val1;
         exp_pkt.rs2_value    = m[sel].val2;
         exp_pkt.dest_reg_idx = REG_W'(m[sel].dest);
         exp_pkt.alu_func     = FUNC_W'(m[sel].func);
         exp_pkt.rob_entry    = ROB_W'(m[sel].rob);
         exp_clr[sel]         = 1'b1;
      end
      exp_mt.dest_reg_idx = bus.id_packet_in.dest_reg_idx;
      exp_mt.rob_entry    = bus.rob2rs_packet_in.rob_entry;
      exp_mt.valid        = bus.id_packet_in.valid && any && (bus.id_packet_in.dest_reg_idx != 0);
      exp_rob.rs1_tag     = bus.mt2rs_packet_in.rs1_tag;
      exp_rob.rs2_tag     = bus.mt2rs_packet_in.rs2_tag;
      check("valid",     128'(bus.valid), 128'(any));
      check("is_packet", 128'(bus.is_packet_out), 128'(exp_pkt));
      check("clear_out", 128'(bus.rs_entry_clear_out), 128'(exp_clr));
      check("rs2mt",     128'(bus.rs2mt_packet_out), 128'(exp_mt));
      check("rs2rob",    128'(bus.rs2rob_packet_out), 128'(exp_rob));
   endtask

   // Next model state from the inputs currently applied.
   task automatic model_step();
      int          slot = -1;
      int          ctag = int'(bus.cdb_packet_in.reg_tag);
      logic [31:0] cval = bus.cdb_packet_in.reg_value;
      if (reset) begin
         for (int i = 0; i < RS_LEN; i++) m[i].busy = 0;
         return;
      end
      for (int i = RS_LEN - 1; i >= 0; i--)
         if (!m[i].busy || bus.rs_entry_clear_in[i]) slot = i;
      for (int i = 0; i < RS_LEN; i++) begin
         if (bus.rs_entry_clear_in[i]) m[i].busy = 0;
         else if (m[i].busy && ctag != 0) begin
            if (!m[i].rdy1 && m[i].tag1 == ctag) begin m[i].rdy1 = 1; m[i].val1 = cval; end
            if (!m[i].rdy2 && m[i].tag2 == ctag) begin m[i].rdy2 = 1; m[i].val2 = cval; end
         end
      end
      if (bus.id_packet_in.valid && slot >= 0) begin
         int t1 = int'(bus.mt2rs_packet_in.rs1_tag);
         int t2 = int'(bus.mt2rs_packet_in.rs2_tag);
         m[slot].busy = 1;
         m[slot].rob  = int'(bus.rob2rs_packet_in.rob_entry);
         m[slot].inst = bus.id_packet_in.inst;
         m[slot].dest = int'(bus.id_packet_in.dest_reg_idx);
         m[slot].func = int'(bus.id_packet_in.alu_func);
         m[slot].tag1 = t1;
         m[slot].tag2 = t2;
         m[slot].rdy1 = 1;
         m[slot].rdy2 = 1;
         if (t1 == 0)                            m[slot].val1 = bus.id_packet_in.rs1_value;
         else if (bus.mt2rs_packet_in.rs1_ready) m[slot].val1 = bus.rob2rs_packet_in.rs1_value;
         else if (t1 == ctag)                    m[slot].val1 = cval;
         else                                    m[slot].rdy1 = 0;
         if (t2 == 0)                            m[slot].val2 = bus.id_packet_in.rs2_value;
         else if (bus.mt2rs_packet_in.rs2_ready) m[slot].val2 = bus.rob2rs_packet_in.rs2_value;
         else if (t2 == ctag)                    m[slot].val2 = cval;
         else                                    m[slot].rdy2 = 0;
      end
   endtask

   // Inputs are applied just after a falling edge; check, advance model, cross the rising edge.
   task automatic cycle();
      #2;
      check_outputs();
      model_step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic set_idle();
      bus.id_packet_in      = '0;
      bus.mt2rs_packet_in   = '0;
      bus.rob2rs_packet_in.rob_entry = '0;
      bus.rob2rs_packet_in.rs1_value = '0;
      bus.rob2rs_packet_in.rs2_value = '0;
      bus.cdb_packet_in     = '0;
      bus.rs_entry_clear_in = '0;
   endtask

   task automatic drive_dispatch(input logic [31:0] inst, input int t1, input bit r1, input int t2,
                                 input bit r2, input logic [31:0] idv, input logic [31:0] robv,
                                 input int rob, input int dest);
      bus.id_packet_in.valid        = 1'b1;
      bus.id_packet_in.inst         = inst;
      bus.id_packet_in.rs1_value    = idv;
      bus.id_packet_in.rs2_value    = idv;
      bus.id_packet_in.dest_reg_idx = REG_W'(dest);
      bus.id_packet_in.alu_func     = FUNC_W'(dest);
      bus.mt2rs_packet_in.rs1_tag   = ROB_W'(t1);
      bus.mt2rs_packet_in.rs2_tag   = ROB_W'(t2);
      bus.mt2rs_packet_in.rs1_ready = r1;
      bus.mt2rs_packet_in.rs2_ready = r2;
      bus.rob2rs_packet_in.rob_entry = ROB_W'(rob);
      bus.rob2rs_packet_in.rs1_value = robv;
      bus.rob2rs_packet_in.rs2_value = robv;
   endtask

   task automatic set_head(input int h);
      bus.rob2rs_packet_in.rob_head_idx = ROB_W'(h);
   endtask

   initial begin
      int rob_ctr = 1;
      for (int i = 0; i < RS_LEN; i++) m[i] = '{default: 0};
      reset = 1'b1;
      set_idle();
      set_head(1);
      repeat (2) @(negedge clock);
      reset = 1'b0;

      // Reset state
      cycle();

      // Ready-at-dispatch instruction issues the following cycle from slot 0
      drive_dispatch(32'hABCDEF12, 0, 0, 0, 0, 32'd1, 32'd0, 1, 3);
      cycle();
      set_idle();
      #1;
      check("t1_inst",  128'(bus.is_packet_out.inst), 128'(32'hABCDEF12));
      check("t1_clear", 128'(bus.rs_entry_clear_out), 128'(8'b0000_0001));
      cycle();

      // Clear frees slot 0; ROB-sourced operands reuse it
      bus.rs_entry_clear_in = 8'b0000_0001;
      cycle();
      set_idle();
      drive_dispatch(32'hABC45F12, 1, 1, 1, 1, 32'd9, 32'd2, 2, 4);
      cycle();
      set_idle();
      #1;
      check("t2_rs1",   128'(bus.is_packet_out.rs1_value), 128'(32'd2));
      check("t2_clear", 128'(bus.rs_entry_clear_out), 128'(8'b0000_0001));
      cycle();
      bus.rs_entry_clear_in = 8'b0000_0001;
      cycle();
      set_idle();

      // CDB wakeup after waiting three cycles
      drive_dispatch(32'h1234_5678, 5, 0, 0, 0, 32'd3, 32'd0, 3, 5);
      cycle();
      set_idle();
      repeat (3) cycle();
      bus.cdb_packet_in = '{reg_tag: ROB_W'(5), reg_value: 32'h77};
      cycle();
      set_idle();
      #1;
      check("t3_rs1",   128'(bus.is_packet_out.rs1_value), 128'(32'h77));
      check("t3_valid", 128'(bus.is_packet_out.valid), 128'(1'b1));
      cycle();
      bus.rs_entry_clear_in = 8'b0000_0001;
      cycle();
      set_idle();

      // Wrap-around age: head 30, ROB 31 is older than ROB 1
      set_head(30);
      drive_dispatch(32'h0000_0001, 0, 0, 0, 0, 32'd11, 32'd0, 1, 6);
      cycle();
      drive_dispatch(32'h0000_0031, 0, 0, 0, 0, 32'd12, 32'd0, 31, 7);
      cycle();
      set_idle();
      #1;
      check("t4_old",   128'(bus.is_packet_out.rob_entry), 128'(5'd31));
      check("t4_clear", 128'(bus.rs_entry_clear_out), 128'(8'b0000_0010));
      bus.rs_entry_clear_in = 8'b0000_0010;
      cycle();
      set_idle();
      #1;
      check("t4_next",  128'(bus.is_packet_out.rob_entry), 128'(5'd1));
      bus.rs_entry_clear_in = 8'b0000_0001;
      cycle();
      set_idle();

      // Fill all slots with waiting operands; ninth dispatch is dropped
      for (int i = 0; i < RS_LEN; i++) begin
         drive_dispatch(32'h5000_0000 + i, 9, 0, 0, 0, 32'd0, 32'd0, 10 + i, i);
         cycle();
      end
      set_idle();
      #1;
      check("t5_full", 128'(bus.valid), 128'(1'b0));
      drive_dispatch(32'h5000_0099, 0, 0, 0, 0, 32'd1, 32'd0, 18, 1);
      cycle();
      set_idle();
      bus.rs_entry_clear_in = 8'b0000_1000;
      #1;
      check("t5_clear_frees", 128'(bus.valid), 128'(1'b1));
      cycle();
      set_idle();

      // Wake the survivors so they are issuing, then reset discards them all
      bus.cdb_packet_in = '{reg_tag: ROB_W'(9), reg_value: 32'hBEEF};
      cycle();
      set_idle();
      cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      #1;
      check("t6_issue", 128'(bus.is_packet_out.valid), 128'(1'b0));
      check("t6_valid", 128'(bus.valid), 128'(1'b1));
      cycle();

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         int h;
         int sel;
         set_idle();
         reset = ($urandom_range(0, 149) == 0);
         h = $urandom_range(0, ROB_LEN - 1);
         set_head(h);
         if ($urandom_range(0, 1) == 1) begin
            bit clash = 0;
            for (int i = 0; i < RS_LEN; i++)
               if (m[i].busy && m[i].rob == rob_ctr) clash = 1;
            if (!clash) begin
               drive_dispatch($urandom, $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                              $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom, $urandom,
                              rob_ctr, $urandom_range(0, 31));
               bus.id_packet_in.rs2_value     = $urandom;
               bus.rob2rs_packet_in.rs2_value = $urandom;
               rob_ctr = (rob_ctr % (ROB_LEN - 1)) + 1;
            end
         end
         if ($urandom_range(0, 1) == 1)
            bus.cdb_packet_in = '{reg_tag: ROB_W'($urandom_range(0, 7)), reg_value: $urandom};
         sel = pick_issue(h);
         if (sel >= 0 && $urandom_range(0, 2) != 0) bus.rs_entry_clear_in[sel] = 1'b1;
         if ($urandom_range(0, 9) == 0) bus.rs_entry_clear_in[$urandom_range(0, RS_LEN - 1)] = 1'b1;
         cycle();
      end
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
